serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised bit-serial adder/subtractor: next generation of the board-level 4-bit LED adder.
//  Operands come from PMOD switch inputs. An asynchronous start strobe (button) launches one operation.
//  Result is computed LSB-first, one bit per clk, then held registered for the LED outputs.
//  Adds subtract mode, a busy/done handshake, a signed-overflow flag and an optional accumulator mode.
// PARAMETERS
//  WIDTH        4   operand width in bits (>=2); result is WIDTH+1 bits
//  SYNC_STAGES  2   flops in the start-strobe synchroniser (>=2)
// PORTS
//  clk     in   1        system clock
//  rst_n   in   1        asynchronous active-low reset
//  a       in   WIDTH    operand A (quasi-static switches; sampled only at capture)
//  b       in   WIDTH    operand B (quasi-static switches; sampled only at capture)
//  sub     in   1        0 = A+B, 1 = A-B (sampled at capture)
//  start   in   1        asynchronous launch strobe (button)
//  o       out  WIDTH+1  result: o[WIDTH-1:0] = sum/difference; o[WIDTH] = carry (add) or borrow (sub)
//  ovf     out  1        two's-complement overflow of the WIDTH-bit result
//  busy    out  1        high while an operation is in flight
//  done    out  1        one-cycle pulse when o/ovf update
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; o=0, ovf=0, busy=0, done=0; synchroniser and edge detector cleared.
//  start passes through SYNC_STAGES flops, then rising-edge detect (prev=0, cur=1) -> launch pulse.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : on launch at cycle E, capture:
//          opA = A; opB = sub ? ~b : b; carry = sub; bit index i = 0; busy=1 from E+1.
//   SHIFT: one bit per cycle for cycles E+1..E+WIDTH:
//          s[i] = opA[i]^opB[i]^carry; carry = majority(opA[i], opB[i], carry); i++.
//          After bit WIDTH-1 -> DONE.
//   DONE : cycle E+WIDTH+1:
//          o <= {sub ? ~carry : carry, s}; ovf <= (opA[W-1]==opB[W-1]) && (s[W-1]!=opA[W-1]);
//          done=1 for this cycle only; busy=0; -> IDLE.
//  Latency: launch-to-done = WIDTH+1 clk. Start-pin-to-launch = SYNC_STAGES+1 clk.
//  o and ovf hold their last value between operations; they never change except in DONE or reset.
//  Launch while busy (SHIFT/DONE) is ignored, not queued. A held button gives exactly one launch.
//  Back-to-back: a launch is accepted in IDLE on the cycle immediately after DONE.
//  Arithmetic is modulo 2^WIDTH on o[WIDTH-1:0].
//   Add:  o[WIDTH] = unsigned carry-out.
//   Sub:  o[WIDTH] = 1 iff A < B (unsigned).
//  Reset mid-operation aborts: all outputs go to reset values; a partial result is never presented.
//  a, b and sub are not synchronised; they may change at any time except the capture cycle.
// CONFIGURATION
//  ACCUMULATE_EN defined:
//   - opA is taken from internal register o[WIDTH-1:0] instead of port a; port a is ignored.
//   - Each launch computes o_low +/- b, giving a running total. Reset clears the total to 0.
//  ACCUMULATE_EN undefined:
//   - opA = a. No feedback path is synthesised.
// TESTING (WIDTH=4, SYNC_STAGES=2 unless noted)
//  1. Reset, then a=7, b=1, sub=0, pulse start:
//     -> done exactly WIDTH+1 clk after launch; o=5'b01000, ovf=1; busy high for 4 cycles.
//  2. a=3, b=5, sub=1, start:
//     -> o=5'b11110 (borrow=1, low=14), ovf=0.
//     Then a=9, b=8, sub=0 -> o=5'b10001, ovf=1.
//  3. Hold start high for 20 clk -> exactly one done pulse.
//     Second rising edge during SHIFT -> ignored; only one done.
//  4. Assert rst_n=0 at the 2nd SHIFT cycle -> o=0, ovf=0, busy=0 immediately; no done afterwards.
//     Next start -> correct result.
//  5. WIDTH=8: a=8'hFF, b=8'h01, add -> o=9'h100, ovf=0, latency 9.
//     a=8'h80, b=8'h01, sub -> o=9'h07F, ovf=1.
//  6. ACCUMULATE_EN, b=6, sub=0, three starts -> o = 6, 12, 18 (5'b10010).
//     Then sub=1, b=2 -> o=5'b00000 (low 2-2=0, no borrow).

Source files
------------

// File: rtl/serial_addsub_if.sv
// Operand / result bundle for the bit-serial adder/subtractor.
// master: switch/button side (drives operands and start strobe)
// slave : the arithmetic unit (drives result and handshake)
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             start;
    logic [WIDTH:0]   o;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output a, b, sub, start,
        input  o, ovf, busy, done
    );

    modport slave (
        input  a, b, sub, start,
        output o, ovf, busy, done
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// A button strobe is synchronised and edge-detected to launch one operation;
// the (WIDTH+1)-bit result and signed-overflow flag are held until the next one.
// Optional build macro ACCUMULATE_EN: operand A is the held result low bits
// (running total), and port a is ignored.
module serial_addsub #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic sovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev;
    logic                   launch;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       s;
    logic                   carry;
    logic                   sub_q;
    logic [WIDTH-1:0]       opa_src;
    logic                   ai;
    logic                   bi;
    logic                   sbit;
    logic                   cnext;

`ifdef ACCUMULATE_EN
    assign opa_src = bus.o[WIDTH-1:0];
`else
    assign opa_src = bus.a;
`endif

    assign launch = sync_p[SYNC_STAGES-1] & ~prev;
    assign ai     = opa[0];
    assign bi     = opb[0];
    assign sbit   = ai ^ bi ^ carry;
    assign cnext  = maj(ai, bi, carry);

    // Start-strobe synchroniser and previous-level flop for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            prev   <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], bus.start};
            prev   <= sync_p[SYNC_STAGES-1];
        end
    end

    // Control FSM; result registers load on the last serial bit so done and o appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.o    <= '0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (launch) begin
                        state    <= S_SHIFT;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.o    <= {sub_q ? ~cnext : cnext, sbit, s[WIDTH-1:1]};
                        bus.ovf  <= sovf(ai, bi, sbit);
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

    // Serial datapath: operands shift right, sum bits enter at the MSB.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && launch) begin
            opa   <= opa_src;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            sub_q <= bus.sub;
        end else if (state == S_SHIFT) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            s     <= {sbit, s[WIDTH-1:1]};
            carry <= cnext;
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub: a WIDTH=4 and a WIDTH=8 instance.
// With ACCUMULATE_EN defined only the running-total sequence is applied.
module tb_serial_addsub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ta = '0;
    logic [7:0] tb_b = '0;
    logic       tsub = 1'b0;
    logic       st4 = 1'b0;
    logic       st8 = 1'b0;
    bit         sel = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(4)) if4();
    serial_addsub_if #(.WIDTH(8)) if8();

    assign if4.a     = ta[3:0];
    assign if4.b     = tb_b[3:0];
    assign if4.sub   = tsub;
    assign if4.start = st4;
    assign if8.a     = ta;
    assign if8.b     = tb_b;
    assign if8.sub   = tsub;
    assign if8.start = st8;

    serial_addsub #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    serial_addsub #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    logic [8:0] o_obs;
    logic       ovf_obs, busy_obs, done_obs;

    always_comb begin
        if (sel) begin
            o_obs    = if8.o;
            ovf_obs  = if8.ovf;
            busy_obs = if8.busy;
            done_obs = if8.done;
        end else begin
            o_obs    = {4'b0, if4.o};
            ovf_obs  = if4.ovf;
            busy_obs = if4.busy;
            done_obs = if4.done;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) st8 = v;
        else     st4 = v;
    endtask

    // One full operation: latency from start pin, busy length, result and done width.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [8:0] eo, input logic eovf);
        int n = 0;
        int nb = 0;
        bit seen = 1'b0;
        int w = sel ? 8 : 4;
        @(negedge clk);
        ta = a; tb_b = b; tsub = s;
        set_start(1'b1);
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) set_start(1'b0);
            if (done_obs) seen = 1'b1;
            else if (busy_obs) nb++;
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(2 + w + 1));
        check({tag, " busy cycles"}, 32'(nb), 32'(w));
        check({tag, " o"}, 32'(o_obs), 32'(eo));
        check({tag, " ovf"}, 32'(ovf_obs), 32'(eovf));
        check({tag, " busy at done"}, 32'(busy_obs), 32'd0);
        @(posedge clk); #1;
        check({tag, " done width"}, 32'(done_obs), 32'd0);
    endtask

    task automatic count_dones(input int cycles, input int hold, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (i == hold) set_start(1'b0);
            if (done_obs) cnt++;
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy_obs && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) set_start(1'b0);
        end
        check({tag, " busy reached"}, 32'(busy_obs), 32'd1);
    endtask

    initial begin
        int nd;
        sel = 1'b0;
        #1;
        check("reset o4", 32'(if4.o), 32'd0);
        check("reset busy4", 32'(if4.busy), 32'd0);
        check("reset done4", 32'(if4.done), 32'd0);
        check("reset o8", 32'(if8.o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef ACCUMULATE_EN
        do_op("acc +6 #1", 8'hA5, 8'd6, 1'b0, 9'b0_0110, 1'b0);
        do_op("acc +6 #2", 8'h5A, 8'd6, 1'b0, 9'b0_1100, 1'b1);
        do_op("acc +6 #3", 8'h00, 8'd6, 1'b0, 9'b1_0010, 1'b0);
        do_op("acc -2", 8'hFF, 8'd2, 1'b1, 9'b0_0000, 1'b0);
`else
        do_op("7+1", 8'd7, 8'd1, 1'b0, 9'b0_1000, 1'b1);
        do_op("3-5", 8'd3, 8'd5, 1'b1, 9'b1_1110, 1'b0);
        do_op("9+8", 8'd9, 8'd8, 1'b0, 9'b1_0001, 1'b1);

        // Held button: one launch only.
        @(negedge clk);
        ta = 8'd2; tb_b = 8'd3; tsub = 1'b0;
        set_start(1'b1);
        count_dones(35, 20, nd);
        check("held start dones", 32'(nd), 32'd1);
        check("held start o", 32'(o_obs), 32'b0_0101);

        // Second rising edge while shifting is ignored.
        @(negedge clk);
        ta = 8'd6; tb_b = 8'd6; tsub = 1'b0;
        set_start(1'b1);
        wait_busy("retrigger");
        @(negedge clk);
        set_start(1'b1);
        count_dones(30, 1, nd);
        check("retrigger dones", 32'(nd), 32'd1);
        check("retrigger o", 32'(o_obs), 32'b0_1100);
        check("retrigger ovf", 32'(ovf_obs), 32'd1);

        // Reset in the 2nd shift cycle aborts the operation.
        @(negedge clk);
        ta = 8'd1; tb_b = 8'd1; tsub = 1'b0;
        set_start(1'b1);
        wait_busy("abort");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort o", 32'(o_obs), 32'd0);
        check("abort ovf", 32'(ovf_obs), 32'd0);
        check("abort busy", 32'(busy_obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(15, 0, nd);
        check("abort no done", 32'(nd), 32'd0);
        do_op("4-9 after abort", 8'd4, 8'd9, 1'b1, 9'b1_1011, 1'b1);

        // Wide instance.
        sel = 1'b1;
        do_op("w8 FF+01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        do_op("w8 80-01", 8'h80, 8'h01, 1'b1, 9'h07F, 1'b1);
        sel = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
